// File: rtl/traffic_light_ctrl_if.sv
// Lane arrival counts in, per-lane lamps and active lane out.
// master drives the car counts, slave is the controller.
interface traffic_light_ctrl_if;
    logic [1:0] car1;
    logic [1:0] car2;
    logic [1:0] car3;
    logic [2:0] light1;
    logic [2:0] light2;
    logic [2:0] light3;
    logic [1:0] active_lane;

    modport master (
        output car1, car2, car3,
        input  light1, light2, light3, active_lane
    );

    modport slave (
        input  car1, car2, car3,
        output light1, light2, light3, active_lane
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Three-lane round-robin traffic light controller.
// Green time scales with cars queued since the lane was last released.
module traffic_light_ctrl #(
    parameter int TICK_DIV      = 50000000,
    parameter int GREEN_BASE    = 5,
    parameter int GREEN_PER_CAR = 2,
    parameter int YELLOW_TIME   = 3,
    parameter int ALLRED_TIME   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    traffic_light_ctrl_if.slave  bus
);
    localparam logic [1:0] S_ALLRED = 2'd0;
    localparam logic [1:0] S_GREEN  = 2'd1;
    localparam logic [1:0] S_YELLOW = 2'd2;

    localparam int GMAX = GREEN_BASE + 3 * GREEN_PER_CAR;
    localparam int TM1  = (GMAX > YELLOW_TIME) ? GMAX : YELLOW_TIME;
    localparam int TMAX = (TM1 > ALLRED_TIME) ? TM1 : ALLRED_TIME;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = $clog2(TICK_DIV);

    logic [PW-1:0] r_pre;
    logic [1:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_snap1, r_snap2, r_snap3;
    logic [1:0]    r_last;
    logic [1:0]    r_active;
    logic [2:0]    r_light1, r_light2, r_light3;

    logic          w_tick, w_expire;
    logic [1:0]    w_pend1, w_pend2, w_pend3;
    logic          w_has1, w_has2, w_has3;
    logic [1:0]    w_pick, w_pick_pend;
    logic [TW-1:0] w_gload;
    logic [1:0]    w_state_nx;
    logic [TW-1:0] w_timer_nx;
    logic [1:0]    w_active_nx;
    logic [1:0]    w_last_nx;
    logic          w_snap_upd;
    logic [2:0]    w_light1, w_light2, w_light3;

    assign w_tick   = (r_pre == PW'(TICK_DIV - 1));
    assign w_expire = w_tick && (r_timer == TW'(1));

    // modulo-4 difference: a 3->0 wrap still counts as one arrival
    assign w_pend1 = bus.car1 - r_snap1;
    assign w_pend2 = bus.car2 - r_snap2;
    assign w_pend3 = bus.car3 - r_snap3;
    assign w_has1  = |w_pend1;
    assign w_has2  = |w_pend2;
    assign w_has3  = |w_pend3;

    always_comb begin
        w_pick = 2'd0;
        unique case (r_last)
            2'd1: begin
                if (w_has2)      w_pick = 2'd2;
                else if (w_has3) w_pick = 2'd3;
                else if (w_has1) w_pick = 2'd1;
            end
            2'd2: begin
                if (w_has3)      w_pick = 2'd3;
                else if (w_has1) w_pick = 2'd1;
                else if (w_has2) w_pick = 2'd2;
            end
            default: begin
                if (w_has1)      w_pick = 2'd1;
                else if (w_has2) w_pick = 2'd2;
                else if (w_has3) w_pick = 2'd3;
            end
        endcase
    end

    always_comb begin
        w_pick_pend = 2'd0;
        unique case (w_pick)
            2'd1:    w_pick_pend = w_pend1;
            2'd2:    w_pick_pend = w_pend2;
            2'd3:    w_pick_pend = w_pend3;
            default: w_pick_pend = 2'd0;
        endcase
    end

    assign w_gload = TW'(GREEN_BASE)
                   + TW'(GREEN_PER_CAR) * TW'(w_pick_pend);

    always_comb begin
        w_state_nx  = r_state;
        w_timer_nx  = r_timer;
        w_active_nx = r_active;
        w_last_nx   = r_last;
        w_snap_upd  = 1'b0;
        if (w_tick && !w_expire)
            w_timer_nx = r_timer - TW'(1);
        unique case (r_state)
            S_GREEN: begin
                if (w_expire) begin
                    w_state_nx = S_YELLOW;
                    w_timer_nx = TW'(YELLOW_TIME);
                    w_snap_upd = 1'b1;
                end
            end
            S_YELLOW: begin
                if (w_expire) begin
                    w_state_nx  = S_ALLRED;
                    w_timer_nx  = TW'(ALLRED_TIME);
                    w_last_nx   = r_active;
                    w_active_nx = 2'd0;
                end
            end
            default: begin
                if (w_expire) begin
                    if (w_pick != 2'd0) begin
                        w_state_nx  = S_GREEN;
                        w_timer_nx  = w_gload;
                        w_active_nx = w_pick;
                    end else begin
                        w_timer_nx  = TW'(1);
                    end
                end
            end
        endcase
    end

    function automatic logic [2:0] lamp(
        input logic [1:0] st,
        input logic       hit
    );
        if (!hit)           return 3'b100;
        if (st == S_GREEN)  return 3'b001;
        if (st == S_YELLOW) return 3'b010;
        return 3'b100;
    endfunction

    assign w_light1 = lamp(w_state_nx, w_active_nx == 2'd1);
    assign w_light2 = lamp(w_state_nx, w_active_nx == 2'd2);
    assign w_light3 = lamp(w_state_nx, w_active_nx == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre    <= '0;
            r_state  <= S_ALLRED;
            r_timer  <= TW'(ALLRED_TIME);
            r_snap1  <= 2'd0;
            r_snap2  <= 2'd0;
            r_snap3  <= 2'd0;
            r_last   <= 2'd3;
            r_active <= 2'd0;
            r_light1 <= 3'b100;
            r_light2 <= 3'b100;
            r_light3 <= 3'b100;
        end else begin
            r_pre    <= w_tick ? '0 : r_pre + PW'(1);
            r_state  <= w_state_nx;
            r_timer  <= w_timer_nx;
            r_last   <= w_last_nx;
            r_active <= w_active_nx;
            r_light1 <= w_light1;
            r_light2 <= w_light2;
            r_light3 <= w_light3;
            if (w_snap_upd) begin
                if (r_active == 2'd1) r_snap1 <= bus.car1;
                if (r_active == 2'd2) r_snap2 <= bus.car2;
                if (r_active == 2'd3) r_snap3 <= bus.car3;
            end
        end
    end

    assign bus.light1      = r_light1;
    assign bus.light2      = r_light2;
    assign bus.light3      = r_light3;
    assign bus.active_lane = r_active;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with fast timing parameters.
// Each scenario starts from reset; lamps checked every clock.
module tb_traffic_light_ctrl;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail = 0;

    traffic_light_ctrl_if tl_if ();

    traffic_light_ctrl #(
        .TICK_DIV      (2),
        .GREEN_BASE    (2),
        .GREEN_PER_CAR (1),
        .YELLOW_TIME   (1),
        .ALLRED_TIME   (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tl_if)
    );

    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_lights(
        input string      tag,
        input int         lane,
        input logic [2:0] col
    );
        chk({tag, ".l1"}, 32'(tl_if.light1), 32'(lane == 1 ? col : RED));
        chk({tag, ".l2"}, 32'(tl_if.light2), 32'(lane == 2 ? col : RED));
        chk({tag, ".l3"}, 32'(tl_if.light3), 32'(lane == 3 ? col : RED));
        chk({tag, ".act"}, 32'(tl_if.active_lane), 32'(lane));
    endtask

    task automatic hold(
        input string      tag,
        input int         n,
        input int         lane,
        input logic [2:0] col
    );
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            expect_lights(tag, lane, col);
        end
    endtask

    task automatic set_cars(input logic [1:0] a, b, c);
        tl_if.car1 = a;
        tl_if.car2 = b;
        tl_if.car3 = c;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expect_lights(tag, 0, RED);
    endtask

    initial begin
        reset = 1'b1;
        set_cars(2'd0, 2'd0, 2'd0);
        repeat (2) @(posedge clk);
        #1;

        // idle: no arrivals, all red
        do_reset("idle_rst");
        hold("idle", 40, 0, RED);

        // single car on lane 2
        set_cars(2'd0, 2'd1, 2'd0);
        do_reset("one_rst");
        hold("one_ar", 1, 0, RED);
        hold("one_g", 6, 2, GRN);
        hold("one_y", 2, 2, YEL);
        hold("one_r", 20, 0, RED);

        // two lanes: lane1 (2 cars) then lane3 (1 car)
        set_cars(2'd2, 2'd0, 2'd1);
        do_reset("two_rst");
        hold("two_ar", 1, 0, RED);
        hold("two_g1", 8, 1, GRN);
        hold("two_y1", 2, 1, YEL);
        hold("two_ar2", 2, 0, RED);
        hold("two_g3", 6, 3, GRN);
        hold("two_y3", 2, 3, YEL);
        hold("two_r", 10, 0, RED);

        // counter wrap 3 -> 0 on lane 1
        set_cars(2'd3, 2'd0, 2'd0);
        do_reset("wrap_rst");
        hold("wrap_ar", 1, 0, RED);
        hold("wrap_g", 10, 1, GRN);
        hold("wrap_y", 2, 1, YEL);
        hold("wrap_ar2", 2, 0, RED);
        tl_if.car1 = 2'd0;
        hold("wrap_g2", 6, 1, GRN);
        hold("wrap_y2", 2, 1, YEL);
        hold("wrap_r", 10, 0, RED);

        // arrival during green neither stretches nor re-grants
        set_cars(2'd0, 2'd1, 2'd0);
        do_reset("late_rst");
        hold("late_ar", 1, 0, RED);
        hold("late_g", 2, 2, GRN);
        tl_if.car2 = 2'd2;
        hold("late_g2", 4, 2, GRN);
        hold("late_y", 2, 2, YEL);
        hold("late_r", 20, 0, RED);

        // reset mid-green, then lane1 wins arbitration
        set_cars(2'd0, 2'd1, 2'd0);
        do_reset("mid_rst0");
        hold("mid_ar", 1, 0, RED);
        hold("mid_g", 2, 2, GRN);
        tl_if.car1 = 2'd1;
        do_reset("mid_rst");
        hold("mid_ar2", 1, 0, RED);
        hold("mid_g1", 6, 1, GRN);
        hold("mid_y1", 2, 1, YEL);
        hold("mid_ar3", 2, 0, RED);
        hold("mid_g2", 6, 2, GRN);
        hold("mid_y2", 2, 2, YEL);
        hold("mid_r", 10, 0, RED);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
